// File: rtl/sparse_cim_mac_stream.sv
// Streaming sparse dot-product MAC: LANES-wide beats accumulated over a valid/ready vector,
// with per-lane zero skipping (threshold or external mask), optional saturation and op/skip counters.

module sparse_cim_lane #(
    parameter int DW = 8
) (
    input  logic signed [DW-1:0]   act_i,
    input  logic signed [DW-1:0]   wgt_i,
    input  logic                   act_m_i,
    input  logic                   wgt_m_i,
    input  logic                   sparse_en_i,
    input  logic                   mask_en_i,
    input  logic [DW-1:0]          thr_i,
    output logic                   keep_o,
    output logic signed [2*DW-1:0] prod_o
);
    logic [DW:0] act_abs, wgt_abs;
    logic        act_nz, wgt_nz;

    always_comb begin
        // one extra bit so |-2^(DW-1)| stays positive
        act_abs = act_i[DW-1] ? (~{act_i[DW-1], act_i} + (DW+1)'(1)) : {1'b0, act_i};
        wgt_abs = wgt_i[DW-1] ? (~{wgt_i[DW-1], wgt_i} + (DW+1)'(1)) : {1'b0, wgt_i};
        act_nz  = mask_en_i ? act_m_i : (act_abs >= {1'b0, thr_i});
        wgt_nz  = mask_en_i ? wgt_m_i : (wgt_abs >= {1'b0, thr_i});
        keep_o  = !sparse_en_i || (act_nz && wgt_nz);
        prod_o  = keep_o ? (2*DW)'(act_i) * (2*DW)'(wgt_i) : '0;
    end
endmodule

module sparse_cim_mac_stream #(
    parameter int LANES             = 16,
    parameter int DATA_WIDTH        = 8,
    parameter int ACC_WIDTH         = 32,
    parameter int DEFAULT_THRESHOLD = 2,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        cfg_sparse_en,
    input  logic                        cfg_saturate,
    input  logic [DATA_WIDTH-1:0]       cfg_threshold,
    input  logic                        cfg_mask_en,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_last,
    input  logic [LANES*DATA_WIDTH-1:0] in_act,
    input  logic [LANES*DATA_WIDTH-1:0] in_wgt,
    input  logic [LANES-1:0]            in_act_mask,
    input  logic [LANES-1:0]            in_wgt_mask,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_WIDTH-1:0]        out_result,
    output logic [CNT_WIDTH-1:0]        out_total_ops,
    output logic [CNT_WIDTH-1:0]        out_skipped_ops,
    output logic                        out_sat,
    output logic                        busy
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = ACC_WIDTH;
    localparam int SW = 2*DW + $clog2(LANES) + 1;
    localparam int EW = ((AW > SW) ? AW : SW) + 1;
    localparam int PW = $clog2(LANES+1);
    localparam logic signed [EW-1:0] MAXV = {{(EW-AW+1){1'b0}}, {(AW-1){1'b1}}};
    localparam logic signed [EW-1:0] MINV = {{(EW-AW+1){1'b1}}, {(AW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_HOLD} state_t;
    state_t state_q, state_d;
    logic   drain_q, drain_d, run_q;

    logic                  cfg_sparse_q, cfg_sat_q, cfg_mask_q;
    logic [DW-1:0]         cfg_thr_q;
    logic                  sparse_use, mask_use;
    logic [DW-1:0]         thr_raw, thr_use;

    logic [LANES-1:0]            keep;
    logic [LANES-1:0][2*DW-1:0]  lane_prod;
    logic [PW-1:0]               skip_cnt;

    logic                        s1_vld_q;
    logic [LANES-1:0][2*DW-1:0]  s1_prod_q;
    logic [PW-1:0]               s1_skip_q;

    logic [AW-1:0]        acc_q, acc_d;
    logic [CNT_WIDTH-1:0] tot_q, tot_d, skp_q, skp_d;
    logic                 sat_q, sat_d;
    logic signed [SW-1:0] sum;
    logic signed [EW-1:0] wide;
    logic [CNT_WIDTH:0]   tot_sum, skp_sum;
    logic                 accept, first;

    assign first    = (state_q == S_IDLE);
    assign in_ready = run_q && (state_q == S_IDLE || state_q == S_ACCUM);
    assign accept   = in_valid && in_ready;

    // the first beat of a vector sees live config; later beats use the latched copy
    assign sparse_use = first ? cfg_sparse_en : cfg_sparse_q;
    assign mask_use   = first ? cfg_mask_en   : cfg_mask_q;
    assign thr_raw    = first ? cfg_threshold : cfg_thr_q;
    assign thr_use    = (thr_raw == '0) ? DW'(DEFAULT_THRESHOLD) : thr_raw;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sparse_cim_lane #(.DW(DW)) u_lane (
            .act_i       (in_act[i*DW +: DW]),
            .wgt_i       (in_wgt[i*DW +: DW]),
            .act_m_i     (in_act_mask[i]),
            .wgt_m_i     (in_wgt_mask[i]),
            .sparse_en_i (sparse_use),
            .mask_en_i   (mask_use),
            .thr_i       (thr_use),
            .keep_o      (keep[i]),
            .prod_o      (lane_prod[i])
        );
    end

    always_comb begin
        skip_cnt = '0;
        for (int i = 0; i < LANES; i++) skip_cnt = skip_cnt + PW'(!keep[i]);
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++)
            sum = sum + {{(SW-2*DW){s1_prod_q[i][2*DW-1]}}, s1_prod_q[i]};
        wide  = {{(EW-AW){acc_q[AW-1]}}, acc_q} + {{(EW-SW){sum[SW-1]}}, sum};
        acc_d = wide[AW-1:0];
        sat_d = sat_q;
        if (cfg_sat_q) begin
            if (wide > MAXV) begin
                acc_d = MAXV[AW-1:0];
                sat_d = 1'b1;
            end else if (wide < MINV) begin
                acc_d = MINV[AW-1:0];
                sat_d = 1'b1;
            end
        end
        tot_sum = {1'b0, tot_q} + (CNT_WIDTH+1)'(LANES);
        skp_sum = {1'b0, skp_q} + (CNT_WIDTH+1)'(s1_skip_q);
        tot_d   = tot_sum[CNT_WIDTH] ? '1 : tot_sum[CNT_WIDTH-1:0];
        skp_d   = skp_sum[CNT_WIDTH] ? '1 : skp_sum[CNT_WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE:  if (accept) begin
                         state_d = in_last ? S_DRAIN : S_ACCUM;
                         drain_d = 1'b0;
                     end
            S_ACCUM: if (accept && in_last) begin
                         state_d = S_DRAIN;
                         drain_d = 1'b0;
                     end
            S_DRAIN: if (drain_q) state_d = S_HOLD;
                     else         drain_d = 1'b1;
            S_HOLD:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            drain_q      <= 1'b0;
            run_q        <= 1'b0;
            cfg_sparse_q <= 1'b0;
            cfg_sat_q    <= 1'b0;
            cfg_mask_q   <= 1'b0;
            cfg_thr_q    <= '0;
            s1_vld_q     <= 1'b0;
            s1_prod_q    <= '0;
            s1_skip_q    <= '0;
            acc_q        <= '0;
            tot_q        <= '0;
            skp_q        <= '0;
            sat_q        <= 1'b0;
        end else if (clear) begin
            state_q  <= S_IDLE;
            drain_q  <= 1'b0;
            run_q    <= 1'b1;
            s1_vld_q <= 1'b0;
            acc_q    <= '0;
            tot_q    <= '0;
            skp_q    <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            run_q    <= 1'b1;
            s1_vld_q <= accept;
            if (accept) begin
                s1_prod_q <= lane_prod;
                s1_skip_q <= skip_cnt;
            end
            // S1 is always empty in IDLE, so zeroing never collides with an S2 update
            if (accept && first) begin
                cfg_sparse_q <= cfg_sparse_en;
                cfg_sat_q    <= cfg_saturate;
                cfg_mask_q   <= cfg_mask_en;
                cfg_thr_q    <= cfg_threshold;
                acc_q        <= '0;
                tot_q        <= '0;
                skp_q        <= '0;
                sat_q        <= 1'b0;
            end else if (s1_vld_q) begin
                acc_q <= acc_d;
                tot_q <= tot_d;
                skp_q <= skp_d;
                sat_q <= sat_d;
            end
        end
    end

    assign out_valid       = (state_q == S_HOLD);
    assign busy            = (state_q != S_IDLE);
    assign out_result      = acc_q;
    assign out_total_ops   = tot_q;
    assign out_skipped_ops = skp_q;
    assign out_sat         = sat_q;
endmodule

// File: tb/tb_sparse_cim_mac_stream.sv
// Randomized bench for sparse_cim_mac_stream: a 32-bit and a 16-bit accumulator instance share
// stimulus and are compared against a plain-arithmetic dot-product model.

module tb_sparse_cim_mac_stream;
    localparam int L  = 16;
    localparam int DW = 8;
    localparam int CW = 16;

    logic clk = 0, rst_n = 0, clear = 0;
    logic cfg_sparse_en = 0, cfg_saturate = 0, cfg_mask_en = 0;
    logic [DW-1:0] cfg_threshold = 0;
    logic in_valid = 0, in_last = 0, out_ready = 0;
    logic [L*DW-1:0] in_act = 0, in_wgt = 0;
    logic [L-1:0] in_act_mask = 0, in_wgt_mask = 0;

    logic i_rdy, o32_valid, o32_sat, o32_busy, i16_rdy, o16_valid, o16_sat, o16_busy;
    logic [31:0] o32_res;
    logic [15:0] o16_res;
    logic [CW-1:0] o32_tot, o32_skp, o16_tot, o16_skp;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    sparse_cim_mac_stream #(.ACC_WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_sparse_en(cfg_sparse_en),
        .cfg_saturate(cfg_saturate), .cfg_threshold(cfg_threshold), .cfg_mask_en(cfg_mask_en),
        .in_valid(in_valid), .in_ready(i_rdy), .in_last(in_last), .in_act(in_act), .in_wgt(in_wgt),
        .in_act_mask(in_act_mask), .in_wgt_mask(in_wgt_mask), .out_valid(o32_valid),
        .out_ready(out_ready), .out_result(o32_res), .out_total_ops(o32_tot),
        .out_skipped_ops(o32_skp), .out_sat(o32_sat), .busy(o32_busy));

    sparse_cim_mac_stream #(.ACC_WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_sparse_en(cfg_sparse_en),
        .cfg_saturate(cfg_saturate), .cfg_threshold(cfg_threshold), .cfg_mask_en(cfg_mask_en),
        .in_valid(in_valid), .in_ready(i16_rdy), .in_last(in_last), .in_act(in_act), .in_wgt(in_wgt),
        .in_act_mask(in_act_mask), .in_wgt_mask(in_wgt_mask), .out_valid(o16_valid),
        .out_ready(out_ready), .out_result(o16_res), .out_total_ops(o16_tot),
        .out_skipped_ops(o16_skp), .out_sat(o16_sat), .busy(o16_busy));

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // vector under test and the config it was started with
    logic [L*DW-1:0] q_act[$], q_wgt[$];
    logic [L-1:0]    q_am[$], q_wm[$];
    bit s_sp, s_sat, s_mask;
    int s_thr;
    longint g_res32, g_res16;
    int g_tot, g_skp, g_sat32, g_sat16;

    function automatic longint lane(input logic [L*DW-1:0] v, input int i);
        logic signed [DW-1:0] x;
        x = v[i*DW +: DW];
        return longint'(x);
    endfunction

    function automatic void model(input int aw, output longint res, output bit sat,
                                  output int skp, output int tot);
        longint half, m, r;
        int thr;
        half = longint'(1) << (aw-1);
        m    = half * 2;
        thr  = (s_thr == 0) ? 2 : s_thr;
        res = 0; sat = 0; skp = 0; tot = 0;
        for (int b = 0; b < q_act.size(); b++) begin
            longint sum;
            sum = 0;
            for (int i = 0; i < L; i++) begin
                longint a, w;
                bit anz, wnz;
                a   = lane(q_act[b], i);
                w   = lane(q_wgt[b], i);
                anz = s_mask ? q_am[b][i] : (((a < 0) ? -a : a) >= thr);
                wnz = s_mask ? q_wm[b][i] : (((w < 0) ? -w : w) >= thr);
                if (!s_sp || (anz && wnz)) sum += a * w;
                else skp++;
            end
            tot += L;
            res += sum;
            if (s_sat) begin
                if (res > half - 1) begin res = half - 1; sat = 1; end
                else if (res < -half) begin res = -half; sat = 1; end
            end else begin
                r = (res + half) % m;
                if (r < 0) r += m;
                res = r - half;
            end
        end
        if (tot > 65535) tot = 65535;
        if (skp > 65535) skp = 65535;
    endfunction

    function automatic logic [L*DW-1:0] splat(input logic [DW-1:0] lo, input logic [DW-1:0] hi);
        logic [L*DW-1:0] v;
        for (int i = 0; i < L; i++) v[i*DW +: DW] = (i < 8) ? lo : hi;
        return v;
    endfunction

    task automatic fill(input int nb, input logic [DW-1:0] alo, input logic [DW-1:0] ahi,
                        input logic [DW-1:0] w, input logic [L-1:0] am, input logic [L-1:0] wm);
        q_act.delete(); q_wgt.delete(); q_am.delete(); q_wm.delete();
        for (int b = 0; b < nb; b++) begin
            q_act.push_back(splat(alo, ahi));
            q_wgt.push_back(splat(w, w));
            q_am.push_back(am);
            q_wm.push_back(wm);
        end
    endtask

    // Entered and left at #1 after a posedge.
    task automatic run_vec(input int hold, input bit scramble);
        int lat, guard;
        bit rdy, stable;
        longint e32, e16;
        bit es32, es16;
        int eskp, etot;
        s_sp = cfg_sparse_en; s_sat = cfg_saturate; s_mask = cfg_mask_en; s_thr = int'(cfg_threshold);
        out_ready = 0;
        for (int b = 0; b < q_act.size(); b++) begin
            if (b > 0 && scramble && $urandom_range(0, 3) == 0) begin
                in_valid = 0;
                @(posedge clk); #1;
            end
            in_valid = 1; in_act = q_act[b]; in_wgt = q_wgt[b];
            in_act_mask = q_am[b]; in_wgt_mask = q_wm[b];
            in_last = (b == q_act.size() - 1);
            guard = 0; rdy = 0;
            while (!rdy && guard < 20) begin
                @(negedge clk); rdy = i_rdy;
                @(posedge clk); #1;
                guard++;
            end
            if (b == 0) chk("first_accept_cycles", guard, 1);
            else if (!rdy) chk("beat_accept", 0, 1);
            if (b == 0 && scramble) begin
                cfg_sparse_en = $urandom; cfg_saturate = $urandom; cfg_mask_en = $urandom;
                cfg_threshold = $urandom;
            end
        end
        in_valid = 0; in_last = 0;
        lat = 0;
        @(negedge clk);
        while (!o32_valid && lat < 20) begin @(negedge clk); lat++; end
        chk("latency", lat, 2);
        g_res32 = longint'($signed(o32_res)); g_res16 = longint'($signed(o16_res));
        g_tot = int'(o32_tot); g_skp = int'(o32_skp); g_sat32 = int'(o32_sat); g_sat16 = int'(o16_sat);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); @(negedge clk);
            stable = o32_valid && o16_valid && !i_rdy && o32_busy &&
                     (longint'($signed(o32_res)) == g_res32) && (int'(o32_tot) == g_tot) &&
                     (longint'($signed(o16_res)) == g_res16) && (int'(o32_skp) == g_skp);
            chk("hold_stable", stable, 1);
        end
        out_ready = 1;
        model(32, e32, es32, eskp, etot);
        model(16, e16, es16, eskp, etot);
        chk("res32", g_res32, e32);
        chk("res16", g_res16, e16);
        chk("sat32", g_sat32, es32);
        chk("sat16", g_sat16, es16);
        chk("total_ops", g_tot, etot);
        chk("skipped_ops", g_skp, eskp);
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic set_cfg(input bit sp, input bit sat, input bit msk, input int thr);
        cfg_sparse_en = sp; cfg_saturate = sat; cfg_mask_en = msk; cfg_threshold = DW'(thr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", i_rdy, 0);
        chk("rst_out_valid", o32_valid, 0);
        chk("rst_result", o32_res, 0);
        chk("rst_counters", {o32_tot, o32_skp}, 0);
        chk("rst_sat_busy", {o32_sat, o32_busy}, 0);
        @(posedge clk); #1 rst_n = 1;
        repeat (2) @(posedge clk); #1;

        set_cfg(0, 0, 0, 0);
        fill(1, 8'h03, 8'h03, 8'hFE, '0, '0);
        run_vec(0, 0);
        chk("dense_res", g_res32, -96);
        chk("dense_cnt", {g_tot, g_skp}, {32'd16, 32'd0});

        set_cfg(1, 0, 0, 0);
        fill(1, 8'h01, 8'h05, 8'h04, '0, '0);
        run_vec(0, 0);
        chk("thr_res", g_res32, 160);
        chk("thr_skip", g_skp, 8);

        set_cfg(0, 0, 0, 0);
        fill(4, 8'h01, 8'h01, 8'h01, '0, '0);
        run_vec(5, 0);
        chk("multi_res", g_res32, 64);
        chk("multi_tot", g_tot, 64);

        set_cfg(0, 1, 0, 0);
        fill(2, 8'h80, 8'h80, 8'h80, '0, '0);
        run_vec(1, 0);
        chk("sat16_res", g_res16, 32767);
        chk("sat16_flag", g_sat16, 1);
        set_cfg(0, 0, 0, 0);
        run_vec(0, 0);
        chk("wrap16_res", g_res16, 0);
        chk("wrap16_flag", g_sat16, 0);

        set_cfg(1, 0, 1, 0);
        fill(1, 8'h01, 8'h01, 8'h01, 16'h00FF, 16'h0F0F);
        run_vec(0, 0);
        chk("mask_res", g_res32, 4);
        chk("mask_skip", g_skp, 12);

        // clear mid-vector, with a final beat presented in the same cycle
        set_cfg(0, 0, 0, 0);
        in_act = splat(8'h07, 8'h07); in_wgt = splat(8'h07, 8'h07);
        in_valid = 1; in_last = 0;
        repeat (2) begin @(posedge clk); #1; end
        clear = 1; in_last = 1;
        @(posedge clk); #1;
        clear = 0; in_valid = 0; in_last = 0;
        seen = 0;
        repeat (6) begin @(negedge clk); if (o32_valid) seen = 1; end
        chk("clr_no_valid", seen, 0);
        chk("clr_busy", o32_busy, 0);
        @(posedge clk); #1;
        fill(1, 8'h02, 8'h02, 8'h03, '0, '0);
        run_vec(0, 0);
        chk("clr_next_res", g_res32, 96);
        chk("clr_next_tot", g_tot, 16);

        // reset mid-vector
        in_act = splat(8'h05, 8'h05); in_wgt = splat(8'h05, 8'h05);
        in_valid = 1; in_last = 0;
        @(posedge clk); #1;
        in_valid = 0; rst_n = 0;
        #1;
        chk("rstmid_busy_valid", {o32_busy, o32_valid}, 0);
        chk("rstmid_res_rdy", {o32_res, i_rdy}, 0);
        @(posedge clk); #1 rst_n = 1;
        repeat (2) @(posedge clk); #1;

        for (int v = 0; v < 40; v++) begin
            int nb;
            nb = $urandom_range(1, 5);
            q_act.delete(); q_wgt.delete(); q_am.delete(); q_wm.delete();
            for (int b = 0; b < nb; b++) begin
                logic [L*DW-1:0] a, w;
                for (int i = 0; i < L; i++) begin
                    case ($urandom_range(0, 4))
                        0:       a[i*DW +: DW] = DW'($urandom);
                        1:       a[i*DW +: DW] = 8'h80;
                        default: a[i*DW +: DW] = DW'($urandom_range(0, 6) - 3);
                    endcase
                    case ($urandom_range(0, 4))
                        0:       w[i*DW +: DW] = DW'($urandom);
                        1:       w[i*DW +: DW] = 8'h80;
                        default: w[i*DW +: DW] = DW'($urandom_range(0, 6) - 3);
                    endcase
                end
                q_act.push_back(a); q_wgt.push_back(w);
                q_am.push_back(L'($urandom)); q_wm.push_back(L'($urandom));
            end
            set_cfg($urandom, $urandom, $urandom,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 4)));
            run_vec($urandom_range(0, 3), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
